rv_dmem_arb: RTL and testbench

Two-port arbiter and access sequencer in front of `rv_dmem`. It lets the core load/store unit (port 0) and the FP-multiply unit's operand/result port (port 1) share the single data memory. A 3-state FSM sequences each access, validates the address, and returns a registered read or write response to the owner.

---
 rtl/rv_dmem_pkg.sv | 34 +++
 rtl/rv_dmem_arb_if.sv | 36 +++
 rtl/rv_dmem_arb_pick.sv | 38 +++
 rtl/rv_dmem_arb.sv | 128 ++++++++++++
 tb/tb_rv_dmem_arb.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_dmem_pkg.sv
// Shared definitions for the data-memory arbiter and rv_dmem.
// FSM encoding, port indices, memory geometry, address check.
package rv_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [31:0] DMEM_BASE  = 32'h0000_1000;
  localparam int unsigned DMEM_WORDS = 1024;

  // Word aligned and inside [base, base + 4*words).
  // The subtraction is unsigned, so addresses below base
  // wrap to large offsets and also fail the span test.
  function automatic logic addr_ok(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned words
  );
    logic [31:0] off;
    logic [31:0] span;
    off  = addr - base;
    span = 32'(words << 2);
    return (addr[1:0] == 2'b00) &&
           (addr >= base) &&
           (off < span);
  endfunction

endpackage

// File: rtl/rv_dmem_arb_if.sv
// One requester port of rv_dmem_arb: req/we/addr/wdata in,
// gnt/rvalid/rdata/err out. master = requester, slave = arbiter.
interface rv_dmem_arb_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );

endinterface

// File: rtl/rv_dmem_arb_pick.sv
// Two-way winner picker: req[1:0], last -> one-hot win[1:0].
// DMEM_ARB_RR_EN selects round-robin; otherwise port 0 wins ties.
module rv_dmem_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

`ifdef DMEM_ARB_RR_EN

  // On a tie, favour the port that was not granted last.
  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b11): win = last ? 2'b01 : 2'b10;
      (req == 2'b01): win = 2'b01;
      (req == 2'b10): win = 2'b10;
      default:        win = 2'b00;
    endcase
  end

`else

  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      req[0]:         win = 2'b01;
      (req == 2'b10): win = 2'b10;
      default:        win = 2'b00;
    endcase
  end

`endif

endmodule

// File: rtl/rv_dmem_arb.sv
// Two-port arbiter/sequencer in front of rv_dmem (IDLE->ACCESS->RESP).
// Ports: clk, rst_n, m0/m1 (rv_dmem_arb_if.slave), mem_we/addr/wdata out,
// mem_rdata in. Macro DMEM_ARB_RR_EN enables round-robin tie-breaking.
module rv_dmem_arb
  import rv_dmem_pkg::*;
#(
  parameter logic [31:0] BASE  = DMEM_BASE,
  parameter int unsigned WORDS = DMEM_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_dmem_arb_if.slave m0,
  rv_dmem_arb_if.slave m1,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata
);

  arb_state_e  state;
  arb_state_e  state_n;

  logic [1:0]  req;
  logic [1:0]  win;
  logic        last;
  logic        idle;
  logic        grant;

  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        owner;

  logic        ok;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        resp;

  assign req   = {m1.req, m0.req};
  assign idle  = (state == IDLE);
  assign grant = idle & (|req);

  rv_dmem_arb_pick u_pick (
    .req  (req),
    .last (last),
    .win  (win)
  );

  assign m0.gnt = idle & win[0];
  assign m1.gnt = idle & win[1];

`ifdef DMEM_ARB_RR_EN

  // Port that won the most recent grant; port 1 after reset
  // so that port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT1;
    end else if (grant) begin
      last <= win[1];
    end
  end

`else

  assign last = PORT1;

`endif

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = grant ? ACCESS : IDLE;
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= 32'h0;
      cmd_wdata <= 32'h0;
      owner     <= PORT0;
    end else if (grant) begin
      cmd_we    <= win[1] ? m1.we    : m0.we;
      cmd_addr  <= win[1] ? m1.addr  : m0.addr;
      cmd_wdata <= win[1] ? m1.wdata : m0.wdata;
      owner     <= win[1];
    end
  end

  assign ok        = addr_ok(cmd_addr, BASE, WORDS);
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign mem_we    = (state == ACCESS) & cmd_we & ok;

  // Read data is captured at the same edge that commits a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      rdata_q <= (!cmd_we && ok) ? mem_rdata : 32'h0;
      err_q   <= !ok;
    end
  end

  assign resp = (state == RESP);

  assign m0.rvalid = resp & (owner == PORT0);
  assign m0.rdata  = m0.rvalid ? rdata_q : 32'h0;
  assign m0.err    = m0.rvalid & err_q;

  assign m1.rvalid = resp & (owner == PORT1);
  assign m1.rdata  = m1.rvalid ? rdata_q : 32'h0;
  assign m1.err    = m1.rvalid & err_q;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Testbench for rv_dmem_arb: transaction-level model checked every cycle
// plus directed vectors with hand-computed results.
module tb_rv_dmem_arb;
  import rv_dmem_pkg::*;

  localparam logic [31:0] BASE  = DMEM_BASE;
  localparam int          WORDS = DMEM_WORDS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  rv_dmem_arb_if m0_if ();
  rv_dmem_arb_if m1_if ();

  rv_dmem_arb #(
    .BASE  (BASE),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int we_cnt = 0;
  int rv1_cnt = 0;

  // Environment: stands in for rv_dmem.
  logic [31:0] tb_mem [WORDS];
  logic [31:0] env_off;
  assign env_off   = mem_addr - BASE;
  assign mem_rdata = (env_off < 32'(4 * WORDS)) ?
                     tb_mem[env_off[11:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (env_off < 32'(4 * WORDS)) tb_mem[env_off[11:2]] <= mem_wdata;
    end
  end

  always @(negedge clk) if (m1_if.rvalid) rv1_cnt++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Transaction model: one access at a time, grant -> +1 access -> +2 resp,
  // next grant no earlier than grant + 3.
  logic [31:0] model_mem [WORDS];
  bit          has_txn = 0;
  int          t_acc   = 0;
  bit          t_port  = 0;
  bit          t_we    = 0;
  bit          t_ok    = 0;
  logic [31:0] t_rdata = 0;
  int          free_at = 0;
  bit          m_last  = 1;
  logic [31:0] m_addr  = 0;
  logic [31:0] m_wdata = 0;

  always @(negedge clk) begin
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_mwe;
    logic [31:0] e_rd [2];
    logic        e_er [2];
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    bit          p;
    int          idx;
    e_gnt = 2'b00;
    e_rv  = 2'b00;
    e_mwe = 1'b0;
    e_rd[0] = 0; e_rd[1] = 0;
    e_er[0] = 0; e_er[1] = 0;
    if (!rst_n) begin
      has_txn = 0;
      free_at = cyc + 1;
      m_last  = 1;
      m_addr  = 0;
      m_wdata = 0;
    end
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    if (rst_n) begin
      if (has_txn && cyc == t_acc) e_mwe = t_we && t_ok;
      if (has_txn && cyc == t_acc + 1) begin
        e_rv[t_port] = 1'b1;
        e_rd[t_port] = t_rdata;
        e_er[t_port] = !t_ok;
        has_txn = 0;
      end
      if (cyc >= free_at && (m0_if.req || m1_if.req)) begin
        if (m0_if.req && m1_if.req) begin
`ifdef DMEM_ARB_RR_EN
          p = !m_last;
`else
          p = 0;
`endif
        end else begin
          p = m1_if.req;
        end
        e_gnt[p] = 1'b1;
        m_last = p;
        a = p ? m1_if.addr  : m0_if.addr;
        d = p ? m1_if.wdata : m0_if.wdata;
        w = p ? m1_if.we    : m0_if.we;
        t_ok = (a[1:0] == 0) && (a >= BASE) &&
               ({1'b0, a} < {1'b0, BASE} + 33'(4 * WORDS));
        idx = int'((a - BASE) >> 2);
        if (w && t_ok) model_mem[idx] = d;
        t_rdata = (!w && t_ok) ? model_mem[idx] : 32'h0;
        t_we    = w;
        t_port  = p;
        has_txn = 1;
        t_acc   = cyc + 1;
        free_at = cyc + 3;
        m_addr  = a;
        m_wdata = d;
      end
    end
    chk("m0_gnt", m0_if.gnt, e_gnt[0]);
    chk("m1_gnt", m1_if.gnt, e_gnt[1]);
    chk("mem_we", mem_we, e_mwe);
    chk("m0_rvalid", m0_if.rvalid, e_rv[0]);
    chk("m1_rvalid", m1_if.rvalid, e_rv[1]);
    chk("m0_rdata", m0_if.rdata, e_rd[0]);
    chk("m1_rdata", m1_if.rdata, e_rd[1]);
    chk("m0_err", m0_if.err, e_er[0]);
    chk("m1_err", m1_if.err, e_er[1]);
  end

  task automatic drive(input bit p, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
    end else begin
      m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
    end
  endtask

  task automatic access(input bit p, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat);
    bit got;
    int g;
    @(posedge clk); #1;
    drive(p, 1, w, a, d);
    got = 0;
    g = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p ? m1_if.gnt : m0_if.gnt) begin
        got = 1;
        g = cyc;
      end
    end
    chk("gnt_seen", {31'h0, got}, 1);
    @(posedge clk); #1;
    drive(p, 0, 0, 0, 0);
    got = 0;
    rd = 0;
    er = 0;
    lat = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p ? m1_if.rvalid : m0_if.rvalid) begin
        got = 1;
        rd  = p ? m1_if.rdata : m0_if.rdata;
        er  = p ? m1_if.err   : m0_if.err;
        lat = cyc - g;
      end
    end
    chk("rvalid_seen", {31'h0, got}, 1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          w0;
  int          bad;
  int          seq[$];
  logic [31:0] err_addr [3];

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      tb_mem[i]    = 32'hA500_0000 | i;
      model_mem[i] = 32'hA500_0000 | i;
    end
    tb_mem[1]    = 32'h4040_0000;
    model_mem[1] = 32'h4040_0000;
    rst_n = 0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_rvalid", m0_if.rvalid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Read after reset.
    access(0, 0, 32'h1004, 0, rd, er, lat);
    chk("rd0_data", rd, 32'h4040_0000);
    chk("rd0_err", er, 0);
    chk("rd0_lat", lat, 2);

    // Write then read on port 1.
    w0 = we_cnt;
    access(1, 1, 32'h1008, 32'h3F80_0000, rd, er, lat);
    chk("wr1_err", er, 0);
    chk("wr1_rdata", rd, 0);
    chk("wr1_we_cycles", we_cnt - w0, 1);
    access(1, 0, 32'h1008, 0, rd, er, lat);
    chk("rd1_data", rd, 32'h3F80_0000);
    chk("rd1_err", er, 0);

    // Address errors: below BASE, misaligned, one past the end.
    err_addr[0] = 32'h0000_0FFC;
    err_addr[1] = 32'h0000_1002;
    err_addr[2] = BASE + 32'(4 * WORDS);
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      access(0, 1, err_addr[i], 32'hDEAD_BEEF, rd, er, lat);
      chk("aerr_w_err", er, 1);
      chk("aerr_w_rdata", rd, 0);
      access(0, 0, err_addr[i], 0, rd, er, lat);
      chk("aerr_r_err", er, 1);
      chk("aerr_r_rdata", rd, 0);
    end
    chk("aerr_no_we", we_cnt - w0, 0);
    bad = 0;
    for (int i = 0; i < WORDS; i++)
      if (tb_mem[i] !== model_mem[i]) bad++;
    chk("mem_contents", bad, 0);
    chk("mem_word2", tb_mem[2], 32'h3F80_0000);

    // Tie resolution from a fresh reset.
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    drive(0, 1, 0, 32'h1004, 0);
    drive(1, 1, 0, 32'h1008, 0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (m0_if.gnt) seq.push_back(0);
      if (m1_if.gnt) seq.push_back(1);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    chk("tie_count_ge4", {31'h0, seq.size() >= 4}, 1);
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
      chk("tie_order", seq[i], i % 2);
`else
      chk("tie_order", seq[i], 0);
`endif
    end

    // Reset during ACCESS of a port-1 read.
    @(posedge clk); #1;
    drive(1, 1, 0, 32'h1008, 0);
    @(negedge clk);
    chk("mid_gnt1", m1_if.gnt, 1);
    w0 = rv1_cnt;
    @(posedge clk); #1;
    rst_n = 0;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_rv1", m1_if.rvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    drive(0, 1, 0, 32'h1004, 0);
    drive(1, 1, 0, 32'h1008, 0);
    @(negedge clk);
    chk("post_rst_gnt0", m0_if.gnt, 1);
    chk("post_rst_gnt1", m1_if.gnt, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    chk("mid_no_rv1", rv1_cnt - w0, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
